// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the MEM arbiter slice: the sequencing state
//   encoding and the MEM mode pin encoding.
package mem_arbiter_pkg;

  // Transaction sequencing states of the arbiter.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // MEM mode pin encoding.
  localparam logic MEM_MODE_READ  = 1'b0;
  localparam logic MEM_MODE_WRITE = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// mem_arbiter_rr_picker
//   Combinational round-robin winner selection. The search starts at
//   (ptr+1) mod NUM_REQ and wraps upward, so the last winner has the lowest
//   priority. With CPU_PRIORITY set, requester 0 wins whenever it requests.
// Ports:
//   req        in  NUM_REQ  request vector
//   ptr        in  IDX_W    index of the previous winner
//   grant      out NUM_REQ  one-hot winner (all zero when no request)
//   grant_idx  out IDX_W    index of the winner
module mem_arbiter_rr_picker #(
  parameter int NUM_REQ      = 3,
  parameter bit CPU_PRIORITY = 1'b0,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Offsets 1..NUM_REQ visit every requester once, ending at ptr itself.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    if (CPU_PRIORITY && req[0]) begin
      grant[0]  = 1'b1;
      found     = 1'b1;
    end
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single-port MEM block between NUM_REQ requesters with fair
//   round-robin arbitration and one transaction in flight at a time.
//   Sequence per transaction: IDLE (arbitrate + latch) -> ISSUE (enable one
//   cycle) -> WAIT (MEM_LATENCY cycles, capture read data) -> DONE (pulse).
//   Optional build macro MEM_ARBITER_CPU_PRIORITY_EN: requester 0 wins every
//   arbitration it takes part in; the pointer only follows non-zero winners.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req, req_we       per-requester level request and write flag
//   req_addr          packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata         packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt               one-hot grant, ISSUE through DONE
//   done              one-hot single-cycle completion pulse
//   rdata             captured read data, held until the next read capture
//   mem_enable/mem_mode/mem_address/mem_wdata  to MEM
//   mem_rdata         from MEM
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          mem_enable,
  output logic                          mem_mode,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

`ifdef MEM_ARBITER_CPU_PRIORITY_EN
  localparam bit CPU_PRIO = 1'b1;
`else
  localparam bit CPU_PRIO = 1'b0;
`endif

  arb_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  en_q, en_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      win_q, win_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [IDX_W-1:0]      pick_idx;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  // Unpack the requester buses so the winner can be selected by index.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  mem_arbiter_rr_picker #(
    .NUM_REQ      (NUM_REQ),
    .CPU_PRIORITY (CPU_PRIO)
  ) u_picker (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  // Next-state logic. mem_enable and done are registered so they go high
  // exactly in the ISSUE and DONE cycles respectively.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    en_d    = 1'b0;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = pick_grant;
          win_d   = pick_idx;
          mode_d  = req_we[pick_idx] ? MEM_MODE_WRITE : MEM_MODE_READ;
          addr_d  = addr_arr[pick_idx];
          wdata_d = wdata_arr[pick_idx];
          en_d    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (mode_q == MEM_MODE_READ) begin
            rdata_d = mem_rdata;
          end
          done_d  = gnt_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
`ifdef MEM_ARBITER_CPU_PRIORITY_EN
        // Requester 0 sits outside the rotation, so it never moves the pointer.
        if (win_q != '0) begin
          ptr_d = win_q;
        end
`else
        ptr_d   = win_q;
`endif
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      en_q    <= 1'b0;
      mode_q  <= MEM_MODE_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign mem_enable  = en_q;
  assign mem_mode    = mode_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

endmodule
